// File: rtl/raid_rebuild_ctrl.sv
// ---------------------------------------------------------------------------
// raid_rebuild_ctrl
//
// Purpose:
//    Rebuilds one failed disk of a 3-disk RAID5 array, one row at a time.
//    For each row it reads the two surviving disks, then pulses the recovery
//    writer to rebuild that row onto the failed disk. It then waits for the
//    memory write handshake before moving on to the next row.
//
// Ports:
//    i_clk          system clock, rising edge
//    i_reset        asynchronous, active-high reset
//    i_start        begin a rebuild (only looked at while idle)
//    i_disk_stat    per-disk health, 1 = healthy; exactly one disk may be down
//    i_abort        cancel the run in progress
//    i_rd_valid     read data for the current row is valid
//    i_wr_done      write of the current row has completed
//    o_rd_en        per-disk read enables (the latched surviving-disk mask)
//    o_rd_addr      row address for the reads
//    o_rec_enable   1-cycle pulse: recovery writer captures and writes the row
//    o_last_op      high together with o_rec_enable on the final row
//    o_busy         high whenever a rebuild is in progress
//    o_done         1-cycle pulse when the rebuild completes
//    o_error        sticky error flag, cleared by the next accepted start
//    o_err_code     00 none, 01 bad disk_stat, 10 abort, 11 timeout
//
// Build option:
//    RAID_TIMEOUT_EN  when defined, each read/write wait gives up after
//                     TIMEOUT cycles with err_code 11; otherwise the waits
//                     hold indefinitely.
// ---------------------------------------------------------------------------
module raid_rebuild_ctrl #(
    parameter int ADDR_W   = 8,
    parameter int NUM_ROWS = 4,
    parameter int TIMEOUT  = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [2:0]        i_disk_stat,
    input  logic              i_abort,
    input  logic              i_rd_valid,
    input  logic              i_wr_done,
    output logic [2:0]        o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic              o_rec_enable,
    output logic              o_last_op,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic [1:0]        o_err_code
);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_ISSUE,
        WR_WAIT,
        DONE
    } stateT;

    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(NUM_ROWS - 1);

    // A misconfigured instance (row count outside the address range, or a
    // zero timeout) refuses every start instead of running off the end.
    localparam bit CFG_OK = (NUM_ROWS >= 1) && (NUM_ROWS <= (2 ** ADDR_W)) && (TIMEOUT >= 1);

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_BADSTAT = 2'b01;
    localparam logic [1:0] ERR_ABORT   = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    stateT             r_state;
    logic [2:0]        r_mask;
    logic [ADDR_W-1:0] r_row;

    logic              w_statLegal;
    logic              w_lastRow;
    logic [ADDR_W-1:0] w_nextRow;

    // A start is only accepted when exactly one disk reports failed; the
    // surviving-disk mask is then exactly the pattern to read from.
    assign w_statLegal = CFG_OK && ((i_disk_stat == 3'b011) ||
                                    (i_disk_stat == 3'b101) ||
                                    (i_disk_stat == 3'b110));

    // The row counter stops at the last row instead of wrapping, so the
    // increment is only ever used when we are not on the last row.
    assign w_lastRow = (r_row == LAST_ROW);
    assign w_nextRow = r_row + ADDR_W'(1);

`ifdef RAID_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    logic [WAIT_W-1:0] r_waitCnt;
    logic              w_waitExpired;

    // The counter holds the number of handshake-less cycles already spent
    // in the current wait state, so the TIMEOUT-th such cycle is the one
    // that sees TIMEOUT-1 here; a handshake in that same cycle still wins.
    assign w_waitExpired = (r_waitCnt == WAIT_W'(TIMEOUT - 1));
`endif

    // Main sequencer. State and every output are registered together so
    // each output is a clean function of the state being entered. Pulse
    // outputs default low every cycle and are only raised on the transition
    // into the state that owns them. Abort from any active state wins over
    // whatever handshake arrives in the same cycle.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_mask       <= '0;
            r_row        <= '0;
            o_rd_en      <= '0;
            o_rd_addr    <= '0;
            o_rec_enable <= 1'b0;
            o_last_op    <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_error      <= 1'b0;
            o_err_code   <= ERR_NONE;
`ifdef RAID_TIMEOUT_EN
            r_waitCnt    <= '0;
`endif
        end else begin
            o_rd_en      <= '0;
            o_rec_enable <= 1'b0;
            o_last_op    <= 1'b0;
            o_done       <= 1'b0;

            if ((r_state != IDLE) && i_abort) begin
                r_state    <= IDLE;
                o_busy     <= 1'b0;
                o_error    <= 1'b1;
                o_err_code <= ERR_ABORT;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (i_start) begin
                            if (w_statLegal) begin
                                r_mask     <= i_disk_stat;
                                r_row      <= '0;
                                o_error    <= 1'b0;
                                o_err_code <= ERR_NONE;
                                o_busy     <= 1'b1;
                                o_rd_en    <= i_disk_stat;
                                o_rd_addr  <= '0;
                                r_state    <= RD_REQ;
                            end else begin
                                o_error    <= 1'b1;
                                o_err_code <= ERR_BADSTAT;
                            end
                        end
                    end

                    RD_REQ: begin
`ifdef RAID_TIMEOUT_EN
                        r_waitCnt <= '0;
`endif
                        r_state   <= RD_WAIT;
                    end

                    RD_WAIT: begin
                        if (i_rd_valid) begin
                            o_rec_enable <= 1'b1;
                            o_last_op    <= w_lastRow;
                            r_state      <= WR_ISSUE;
`ifdef RAID_TIMEOUT_EN
                        end else if (w_waitExpired) begin
                            o_busy     <= 1'b0;
                            o_error    <= 1'b1;
                            o_err_code <= ERR_TIMEOUT;
                            r_state    <= IDLE;
                        end else begin
                            r_waitCnt <= r_waitCnt + WAIT_W'(1);
`endif
                        end
                    end

                    WR_ISSUE: begin
`ifdef RAID_TIMEOUT_EN
                        r_waitCnt <= '0;
`endif
                        r_state   <= WR_WAIT;
                    end

                    WR_WAIT: begin
                        if (i_wr_done) begin
                            if (w_lastRow) begin
                                o_done  <= 1'b1;
                                r_state <= DONE;
                            end else begin
                                r_row     <= w_nextRow;
                                o_rd_en   <= r_mask;
                                o_rd_addr <= w_nextRow;
                                r_state   <= RD_REQ;
                            end
`ifdef RAID_TIMEOUT_EN
                        end else if (w_waitExpired) begin
                            o_busy     <= 1'b0;
                            o_error    <= 1'b1;
                            o_err_code <= ERR_TIMEOUT;
                            r_state    <= IDLE;
                        end else begin
                            r_waitCnt <= r_waitCnt + WAIT_W'(1);
`endif
                        end
                    end

                    DONE: begin
                        o_busy  <= 1'b0;
                        r_state <= IDLE;
                    end

                    default: begin
                        o_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_raid_rebuild_ctrl.sv
// ---------------------------------------------------------------------------
// tb_raid_rebuild_ctrl
//
// Directed bench for raid_rebuild_ctrl. Expected read requests, recovery
// pulses and done pulses are queued as each run is started, and a monitor
// pops them as the controller produces them. The timeout scenario is only
// exercised when RAID_TIMEOUT_EN is defined.
// ---------------------------------------------------------------------------
module tb_raid_rebuild_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] diskStat;
    logic       abort;
    logic       rdValid;
    logic       wrDone;

    logic [2:0] rdEn;
    logic [7:0] rdAddr;
    logic       recEnable;
    logic       lastOp;
    logic       busy;
    logic       done;
    logic       error;
    logic [1:0] errCode;

    typedef struct packed {
        logic [2:0] mask;
        logic [7:0] addr;
    } rdExpT;

    rdExpT rdQ[$];
    logic  recQ[$];
    int    doneExp = 0;
    int    nTotal  = 0;
    int    nBad    = 0;

    raid_rebuild_ctrl #(
        .ADDR_W   (8),
        .NUM_ROWS (4),
        .TIMEOUT  (16)
    ) dut (
        .i_clk        (clock),
        .i_reset      (reset),
        .i_start      (start),
        .i_disk_stat  (diskStat),
        .i_abort      (abort),
        .i_rd_valid   (rdValid),
        .i_wr_done    (wrDone),
        .o_rd_en      (rdEn),
        .o_rd_addr    (rdAddr),
        .o_rec_enable (recEnable),
        .o_last_op    (lastOp),
        .o_busy       (busy),
        .o_done       (done),
        .o_error      (error),
        .o_err_code   (errCode)
    );

    // 10 ns clock.
    always #5 clock = ~clock;

    // Hard stop in case some wait is never satisfied.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before the end of the sequence");
        $fatal(1, "[TB] watchdog");
    end

    // One comparison: counts it, and reports it when the observed value
    // differs from the expected one.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nTotal++;
        assert (observed === expected)
        else begin
            nBad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advances to the next falling edge and returns all pulse-style inputs
    // to their idle value; callers then raise whatever this cycle needs.
    task automatic tick();
        @(negedge clock);
        start   = 1'b0;
        abort   = 1'b0;
        rdValid = 1'b0;
        wrDone  = 1'b0;
    endtask

    // Drives the controller-side inputs for the current cycle.
    task automatic applyStimulus(input logic [2:0] stat, input logic st, input logic ab);
        diskStat = stat;
        start    = st;
        abort    = ab;
    endtask

    // Queues what a run should produce: one read per row, one recovery
    // pulse per written row (last_op only on row 3), and optionally done.
    task automatic pushRun(input logic [2:0] mask, input int nRows, input int nRecs, input bit withDone);
        for (int i = 0; i < nRows; i++) rdQ.push_back({mask, 8'(i)});
        for (int i = 0; i < nRecs; i++) recQ.push_back(i == 3);
        if (withDone) doneExp++;
    endtask

    task automatic checkDrained(input string tag);
        checkOutput({tag, "_reads_left"}, rdQ.size(), 0);
        checkOutput({tag, "_recs_left"}, recQ.size(), 0);
        checkOutput({tag, "_done_left"}, doneExp, 0);
    endtask

    // Waits (bounded) for the next read request to appear.
    task automatic waitRead();
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (rdEn !== 3'b000) seen = 1'b1;
        end
        checkOutput("rd_request_wait", seen, 1);
    endtask

    // Services one row: waits for the read request, idles 'gap' cycles in
    // RD_WAIT, returns read data, then completes the write. With 'stray'
    // set it also throws in starts, a wr_done during RD_WAIT and an
    // rd_valid during WR_WAIT, all of which must be ignored. Returns at the
    // falling edge where wr_done is being driven.
    task automatic serviceRow(input int gap, input bit stray);
        waitRead();
        checkOutput("busy_rd_req", busy, 1);
        for (int i = 0; i < gap; i++) begin
            tick();
            if (stray) begin
                wrDone   = 1'b1;
                start    = 1'b1;
                diskStat = 3'b000;
            end
        end
        tick();
        rdValid = 1'b1;
        tick();
        checkOutput("busy_wr_issue", busy, 1);
        if (stray) begin
            tick();
            rdValid = 1'b1;
            start   = 1'b1;
        end
        tick();
        wrDone = 1'b1;
    endtask

    // Scoreboard monitor: every read request, recovery pulse and done pulse
    // the controller produces must match the oldest queued expectation.
    always @(negedge clock) begin
        rdExpT rdExp;
        if (rdEn !== 3'b000) begin
            checkOutput("rd_expected", rdQ.size() != 0, 1);
            if (rdQ.size() != 0) begin
                rdExp = rdQ.pop_front();
                checkOutput("rd_en_addr", {rdEn, rdAddr}, rdExp);
            end
        end
        if (recEnable === 1'b1) begin
            checkOutput("rec_expected", recQ.size() != 0, 1);
            if (recQ.size() != 0) checkOutput("last_op", lastOp, recQ.pop_front());
        end else if (lastOp !== 1'b0) begin
            checkOutput("last_op_without_rec", lastOp, 0);
        end
        if (done === 1'b1) begin
            checkOutput("done_expected", doneExp > 0, 1);
            if (doneExp > 0) doneExp--;
        end
    end

    // Directed sequence.
    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        diskStat = 3'b111;
        abort    = 1'b0;
        rdValid  = 1'b0;
        wrDone   = 1'b0;
        repeat (2) @(negedge clock);
        checkOutput("reset_outputs", {rdEn, rdAddr, recEnable, lastOp, busy, done, error, errCode}, 0);
        tick();
        reset = 1'b0;
        tick();

        $display("[TB] full rebuild with disk 1 failed");
        applyStimulus(3'b101, 1'b1, 1'b0);
        pushRun(3'b101, 4, 4, 1'b1);
        for (int r = 0; r < 4; r++) serviceRow(0, 1'b0);
        tick();
        checkOutput("done_after_last_wr", done, 1);
        checkOutput("busy_in_done", busy, 1);
        tick();
        checkOutput("busy_after_done", busy, 0);
        checkOutput("done_one_cycle", done, 0);
        checkOutput("no_error_run1", {error, errCode}, 0);
        checkDrained("run1");

        $display("[TB] illegal disk_stat starts, then a legal one");
        applyStimulus(3'b111, 1'b1, 1'b0);
        tick();
        checkOutput("bad111_error", {error, errCode}, 3'b101);
        checkOutput("bad111_busy", busy, 0);
        applyStimulus(3'b001, 1'b1, 1'b0);
        tick();
        checkOutput("bad001_error", {error, errCode}, 3'b101);
        checkOutput("bad001_busy", busy, 0);
        applyStimulus(3'b011, 1'b1, 1'b0);
        pushRun(3'b011, 4, 4, 1'b1);
        serviceRow(0, 1'b0);
        checkOutput("error_cleared_by_start", {error, errCode}, 0);
        diskStat = 3'b110;
        for (int r = 1; r < 4; r++) serviceRow(0, 1'b0);
        tick();
        checkOutput("done_run2", done, 1);
        tick();
        checkDrained("run2");

        $display("[TB] abort in row 2 WR_WAIT together with wr_done");
        applyStimulus(3'b110, 1'b1, 1'b0);
        pushRun(3'b110, 3, 3, 1'b0);
        for (int r = 0; r < 3; r++) serviceRow(0, 1'b0);
        abort = 1'b1;
        tick();
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_error", {error, errCode}, 3'b110);
        checkOutput("abort_no_done", done, 0);
        repeat (8) tick();
        abort = 1'b1;
        tick();
        checkOutput("abort_idle_no_effect", {busy, error, errCode}, 4'b0110);
        checkDrained("abort");

        $display("[TB] stray handshakes and starts while busy");
        applyStimulus(3'b110, 1'b1, 1'b0);
        pushRun(3'b110, 4, 4, 1'b1);
        for (int r = 0; r < 4; r++) serviceRow(1, 1'b1);
        tick();
        checkOutput("done_stray", done, 1);
        tick();
        checkOutput("busy_after_stray", busy, 0);
        checkDrained("stray");

        $display("[TB] reset during row 1 WR_WAIT");
        applyStimulus(3'b011, 1'b1, 1'b0);
        pushRun(3'b011, 2, 2, 1'b0);
        serviceRow(0, 1'b0);
        serviceRow(0, 1'b0);
        wrDone = 1'b0;
        reset  = 1'b1;
        #1;
        checkOutput("reset_midrun_outputs", {rdEn, rdAddr, recEnable, lastOp, busy, done, error, errCode}, 0);
        tick();
        reset = 1'b0;
        tick();
        checkOutput("reset_midrun_no_error", {busy, error, errCode}, 0);
        applyStimulus(3'b101, 1'b1, 1'b0);
        pushRun(3'b101, 4, 4, 1'b1);
        for (int r = 0; r < 4; r++) serviceRow(0, 1'b0);
        tick();
        checkOutput("done_after_reset", done, 1);
        tick();
        checkDrained("post_reset");

`ifdef RAID_TIMEOUT_EN
        $display("[TB] read timeout and last-cycle handshake");
        applyStimulus(3'b011, 1'b1, 1'b0);
        pushRun(3'b011, 1, 0, 1'b0);
        waitRead();
        repeat (16) tick();
        checkOutput("busy_16th_wait_cycle", busy, 1);
        tick();
        checkOutput("timeout_busy", busy, 0);
        checkOutput("timeout_error", {error, errCode}, 3'b111);
        checkDrained("timeout");
        applyStimulus(3'b011, 1'b1, 1'b0);
        pushRun(3'b011, 4, 4, 1'b1);
        serviceRow(15, 1'b0);
        for (int r = 1; r < 4; r++) serviceRow(0, 1'b0);
        tick();
        checkOutput("done_after_late_hs", done, 1);
        checkOutput("late_hs_no_error", {error, errCode}, 0);
        tick();
        checkDrained("late_hs");
`endif

        $display("test done: total=%0d bad=%0d", nTotal, nBad);
        $finish;
    end

endmodule
